// File: rtl/capiano_pkg.sv
// Shared frame-buffer geometry and types for the camera writer and the VGA reader.
package capiano_pkg;

  localparam int unsigned FRAME_WORDS_DEFAULT = 38400;
  localparam logic [19:0] BANK0_BASE_DEFAULT  = 20'h00000;
  localparam logic [19:0] BANK1_BASE_DEFAULT  = 20'h10000;

  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_entry_t;

  localparam int unsigned EntryW = $bits(wr_entry_t);

  typedef enum logic [1:0] {CapWait, CapRun, CapFull} cap_state_e;
  typedef enum logic {WrIdle, WrReq} wr_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO of pending SRAM writes; a push on a full FIFO succeeds only if a pop
// happens in the same cycle.
module word_fifo #(
  parameter int unsigned Width = 52,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("word_fifo Depth must be a power of two of at least 2");
  end

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                   (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cam_frame_writer.sv
// Packs camera bytes into 32-bit words and writes whole frames alternately into two SRAM
// banks, publishing the bank that holds the last complete frame.
module cam_frame_writer
  import capiano_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter logic [19:0] BANK0_BASE  = BANK0_BASE_DEFAULT,
  parameter logic [19:0] BANK1_BASE  = BANK1_BASE_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        write,
  output logic [19:0] addr,
  output logic [31:0] data,
  input  logic        workdone,
  output logic        disp_bank,
  output logic        frame_done,
  output logic        overflow
);

  localparam logic [19:0] FrameWordsL = 20'(FRAME_WORDS);

  if (FRAME_WORDS > 32'(BANK1_BASE - BANK0_BASE)) begin : g_frame_too_big
    $error("FRAME_WORDS does not fit between BANK0_BASE and BANK1_BASE");
  end

  function automatic logic [19:0] base_of(input logic bank);
    return bank ? BANK1_BASE : BANK0_BASE;
  endfunction

  cap_state_e  cap_q, cap_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] pack_q, pack_d;
  logic [19:0] wr_word_q, wr_word_d;
  logic        wr_bank_q, wr_bank_d;
  logic        overflow_q, overflow_d;
  wr_state_e   wst_q, wst_d;
  logic        write_q, write_d;
  logic [19:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        disp_bank_q, disp_bank_d;
  logic        frame_done_q, frame_done_d;

  logic        push, pop, fifo_full, fifo_empty;
  wr_entry_t   push_entry, head_entry;

  word_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Capture side: packer and WAIT/RUN/FULL sequencing.
  always_comb begin
    cap_d           = cap_q;
    byte_idx_d      = byte_idx_q;
    pack_d          = pack_q;
    wr_word_d       = wr_word_q;
    wr_bank_d       = wr_bank_q;
    overflow_d      = overflow_q;
    push            = 1'b0;
    push_entry.addr = base_of(wr_bank_q) + wr_word_q;
    push_entry.data = {pix_data, pack_q};
    if (frame_start) begin
      cap_d      = CapRun;
      byte_idx_d = '0;
      pack_d     = '0;
      wr_word_d  = '0;
      wr_bank_d  = ~disp_bank_q;
      overflow_d = 1'b0;
    end else if (cap_q == CapRun && pix_valid) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0: pack_d[7:0]   = pix_data;
        2'd1: pack_d[15:8]  = pix_data;
        2'd2: pack_d[23:16] = pix_data;
        default: begin
          push      = 1'b1;
          // A dropped word still consumes its address slot.
          wr_word_d = wr_word_q + 20'd1;
          if (fifo_full && !pop) overflow_d = 1'b1;
          if (wr_word_d == FrameWordsL) cap_d = CapFull;
        end
      endcase
    end
  end

  // Write side: one outstanding request to ram_ctrl at a time.
  always_comb begin
    wst_d        = wst_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    disp_bank_d  = disp_bank_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    unique case (wst_q)
      WrIdle: begin
        if (!fifo_empty) begin
          wst_d   = WrReq;
          write_d = 1'b1;
          addr_d  = head_entry.addr;
          data_d  = head_entry.data;
        end
      end
      WrReq: begin
        if (workdone) begin
          pop     = 1'b1;
          write_d = 1'b0;
          wst_d   = WrIdle;
          if (cap_q == CapFull &&
              addr_q == base_of(wr_bank_q) + FrameWordsL - 20'd1) begin
            frame_done_d = 1'b1;
            disp_bank_d  = wr_bank_q;
          end
        end
      end
      default: wst_d = WrIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q        <= CapWait;
      byte_idx_q   <= '0;
      pack_q       <= '0;
      wr_word_q    <= '0;
      wr_bank_q    <= 1'b0;
      overflow_q   <= 1'b0;
      wst_q        <= WrIdle;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      disp_bank_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cap_q        <= cap_d;
      byte_idx_q   <= byte_idx_d;
      pack_q       <= pack_d;
      wr_word_q    <= wr_word_d;
      wr_bank_q    <= wr_bank_d;
      overflow_q   <= overflow_d;
      wst_q        <= wst_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      disp_bank_q  <= disp_bank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign write      = write_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign disp_bank  = disp_bank_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Randomised bench for cam_frame_writer: a frame/queue reference model feeds a scoreboard
// that a negedge monitor drains whenever the DUT presents a write.
module tb_cam_frame_writer;

  localparam int unsigned FW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [19:0] B0    = 20'h00000;
  localparam logic [19:0] B1    = 20'h10000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        workdone = 1'b0;
  logic        write;
  logic [19:0] addr;
  logic [31:0] data;
  logic        disp_bank, frame_done, overflow;

  always #5 clk = ~clk;

  cam_frame_writer #(
    .FRAME_WORDS (FW),
    .BANK0_BASE  (B0),
    .BANK1_BASE  (B1),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .write       (write),
    .addr        (addr),
    .data        (data),
    .workdone    (workdone),
    .disp_bank   (disp_bank),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] mbase(input bit b);
    return b ? B1 : B0;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [19:0] occ_q[$];
  logic [7:0]  m_bytes[$];
  bit          m_run = 0, m_full = 0, m_bank = 0, m_disp = 0, m_ovf = 0, m_fd = 0;
  int          m_word = 0;

  always @(posedge clk or negedge rst) begin : model
    bit          pop, was_full, old_disp;
    logic [19:0] a;
    ent_t        e;
    if (!rst) begin
      exp_q.delete(); occ_q.delete(); m_bytes.delete();
      m_run = 0; m_full = 0; m_bank = 0; m_disp = 0; m_ovf = 0; m_fd = 0; m_word = 0;
    end else begin
      pop      = write && workdone;
      was_full = (occ_q.size() == DEPTH);
      old_disp = m_disp;
      m_fd     = 0;
      if (pop && occ_q.size() > 0) begin
        a = occ_q.pop_front();
        if (m_full && a == mbase(m_bank) + 20'(FW - 1)) begin
          m_fd   = 1;
          m_disp = m_bank;
        end
      end
      if (frame_start) begin
        m_run = 1; m_full = 0; m_word = 0; m_bank = ~old_disp; m_ovf = 0;
        m_bytes.delete();
      end else if (m_run && !m_full && pix_valid) begin
        m_bytes.push_back(pix_data);
        if (m_bytes.size() == 4) begin
          e.addr = mbase(m_bank) + 20'(m_word);
          e.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_bytes.delete();
          if (was_full && !pop) m_ovf = 1;
          else begin
            exp_q.push_back(e);
            occ_q.push_back(e.addr);
          end
          m_word++;
          if (m_word == FW) m_full = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int          n_writes = 0;
  int          fd_count = 0;
  logic [19:0] last_addr = '0;
  logic [31:0] last_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("frame_done", frame_done, m_fd);
      check("disp_bank", disp_bank, m_disp);
      check("overflow", overflow, m_ovf);
      if (frame_done) fd_count++;
      if (write) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h, expected no request", addr);
        end else begin
          check("addr", addr, exp_q[0].addr);
          check("data", data, exp_q[0].data);
          if (workdone) begin
            last_addr = exp_q[0].addr;
            last_data = exp_q[0].data;
            void'(exp_q.pop_front());
            n_writes++;
          end
        end
      end
    end
  end

  // ---------------- ram_ctrl responder ----------------
  int lat = 1;
  bit stall = 0;
  bit stray_en = 0;
  bit stray_now = 0;
  int wcnt = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        workdone = 0; wcnt = 0;
      end else if (workdone) begin
        workdone = 0; wcnt = 0;
      end else if (write && !stall) begin
        wcnt++;
        if (wcnt >= lat) workdone = 1;
      end else if (!write && (stray_now || (stray_en && $urandom_range(0, 7) == 0))) begin
        workdone  = 1;
        stray_now = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1; step(); frame_start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pix_valid = 1; pix_data = b; step(); pix_valid = 0;
  endtask

  task automatic send_rand(input int n, input int gap_pct);
    int sent = 0;
    while (sent < n) begin
      if ($urandom_range(0, 99) < gap_pct) pix_valid = 0;
      else begin
        pix_valid = 1; pix_data = 8'($urandom); sent++;
      end
      step();
    end
    pix_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || write) && k < 400) begin
      step(); k++;
    end
    check("drain_done", (exp_q.size() == 0 && !write), 1);
    step(); step();
  endtask

  task automatic wait_write(input int budget);
    int k = 0;
    while (!write && k < budget) begin
      step(); k++;
    end
    check("write_seen", write, 1);
  endtask

  initial begin
    int w0;
    #1;
    step(); step();
    check("reset_write", write, 0);
    check("reset_addr", addr, 0);
    check("reset_data", data, 0);
    check("reset_disp_bank", disp_bank, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_overflow", overflow, 0);
    rst = 1; step();

    // Single word, workdone two cycles after write.
    lat = 2;
    pulse_fs();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    drain();
    check("single_write_count", n_writes, 1);
    check("single_addr", last_addr, 20'h10000);
    check("single_data", last_data, 32'h04030201);
    check("single_disp_bank", disp_bank, 0);

    // Complete frame with latency 1, then the next frame lands in bank 0.
    lat = 1;
    pulse_fs();
    send_rand(4 * FW, 0);
    drain();
    check("frame1_done_count", fd_count, 1);
    check("frame1_disp_bank", disp_bank, 1);
    check("frame1_last_addr", last_addr, B1 + 20'(FW - 1));
    pulse_fs();
    send_rand(4, 0);
    drain();
    check("frame2_first_addr", last_addr, B0);

    // Stalled ram_ctrl: FIFO fills, later words drop, overflow is sticky.
    stall = 1;
    pulse_fs();
    w0 = n_writes;
    send_rand(24, 0);
    check("stall_overflow", overflow, 1);
    stall = 0;
    send_rand(8, 0);
    drain();
    check("stall_write_count", n_writes - w0, 6);
    check("stall_overflow_sticky", overflow, 1);
    pulse_fs();
    check("overflow_cleared", overflow, 0);

    // Restart after six bytes: partial word discarded, restart at bank base.
    w0 = n_writes;
    send_rand(6, 0);
    pulse_fs();
    send_rand(4, 0);
    drain();
    check("restart_write_count", n_writes - w0, 2);
    check("restart_addr", last_addr, mbase(~disp_bank));

    // Randomised frames with gaps, varying latency and stray workdone pulses.
    stray_en = 1;
    for (int f = 0; f < 4; f++) begin
      lat = $urandom_range(1, 3);
      pulse_fs();
      send_rand(4 * FW, 25);
      drain();
    end
    stray_en = 0;

    // Asynchronous reset while a request is outstanding.
    lat = 1;
    stall = 1;
    pulse_fs();
    send_rand(8, 0);
    wait_write(50);
    #2 rst = 0;
    #1;
    check("midreset_write", write, 0);
    check("midreset_addr", addr, 0);
    check("midreset_data", data, 0);
    check("midreset_overflow", overflow, 0);
    stall = 0;
    step();
    rst = 1;
    pix_valid = 1;
    for (int i = 0; i < 12; i++) begin
      pix_data = 8'($urandom);
      step();
      check("post_reset_idle_write", write, 0);
    end
    pix_valid = 0;

    // Stray workdone in idle must change nothing.
    stray_now = 1;
    step(); step();
    check("stray_write", write, 0);
    check("stray_disp_bank", disp_bank, 0);

    pulse_fs();
    send_rand(4 * FW, 10);
    drain();
    check("final_disp_bank", disp_bank, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of run, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Captures the camera byte stream on the `qu_clk` domain and packs every four bytes into one 32-bit word. It writes each frame into one of two SRAM frame banks through the `ram_ctrl` request/`workdone` handshake. It sits between `camera_ctrl` (upstream byte source) and `ram_ctrl` (downstream memory port). It tells the VGA read side which bank holds the last complete frame.

## Interface
Parameters:
- `FRAME_WORDS`, 38400, number of 32-bit words per frame (320×240 RGB565).
- `BANK0_BASE`, 20'h00000, word address of bank 0.
- `BANK1_BASE`, 20'h10000, word address of bank 1.
- `FIFO_DEPTH`, 4, number of pending `{addr,data}` entries; must be a power of two.

Ports:
- `clk`  in  1  system clock (`qu_clk`).
- `rst`  in  1  asynchronous reset, active-low.
- `frame_start`  in  1  one-cycle pulse at the start of a camera frame (from vsync).
- `pix_valid`  in  1  `pix_data` holds a valid byte this cycle.
- `pix_data`  in  8  camera byte.
- `write`  out  1  write request to `ram_ctrl`.
- `addr`  out  20  SRAM word address.
- `data`  out  32  SRAM write data.
- `workdone`  in  1  one-cycle pulse from `ram_ctrl`: current access finished.
- `disp_bank`  out  1  bank holding the last complete frame.
- `frame_done`  out  1  one-cycle pulse when the last word of a frame is written.
- `overflow`  out  1  sticky flag: a word was dropped in the current frame.

## Operation
- Reset values: `write`=0, `addr`=0, `data`=0, `disp_bank`=0, `frame_done`=0, `overflow`=0. The FIFO is empty and the capture FSM is in WAIT.
- Capture FSM, states WAIT / RUN / FULL:
  - WAIT → RUN on `frame_start`. On entry: the packer clears, `wr_word`=0, `wr_bank`=~`disp_bank`, `overflow`=0.
  - RUN: each `pix_valid` byte goes into byte lane `byte_idx` (byte 0 in [7:0], little-endian), and `byte_idx` increments mod 4.
  - When byte 3 is taken, `{base(wr_bank)+wr_word, word}` is pushed and `wr_word` increments.
  - RUN → FULL when `wr_word` reaches `FRAME_WORDS`. FULL ignores `pix_valid`.
  - `frame_start` in any state restarts as in WAIT → RUN. A partial word is discarded. Entries already queued keep their own address and are still written.
- If a push finds the FIFO full and no pop happens that cycle, the word is dropped, `overflow` is set, and `wr_word` still increments, so the address map stays aligned.
- Write FSM, states IDLE / REQ:
  - IDLE with FIFO non-empty → REQ. `write`=1 and `addr`/`data` load from the FIFO head.
  - REQ holds `write`, `addr` and `data` stable until `workdone`=1. Then: pop, `write`=0 next cycle, return to IDLE.
  - `workdone` seen in IDLE is ignored.
- Frame completion: when the popped entry is the word at `base(wr_bank)+FRAME_WORDS-1` and the capture FSM is in FULL for that same bank, then `frame_done` pulses and `disp_bank` ← `wr_bank`.
- Addresses do not wrap within a bank: `FRAME_WORDS` ≤ `BANK1_BASE`−`BANK0_BASE`, which is an elaboration-time requirement.

## Timing
- A byte is accepted every cycle `pix_valid`=1; there is no back-pressure.
- The 4th byte is at cycle t. The entry is in the FIFO at t+1.
- From IDLE with a non-empty FIFO, `write` rises on the next edge.
- Minimum request spacing is 2 cycles: `workdone` at t gives `write`=0 at t+1 and, if the FIFO is non-empty, `write`=1 at t+2.
- A push and pop in the same cycle on a full FIFO both succeed. No drop occurs.
- `frame_done` and the `disp_bank` update occur in the cycle after the final `workdone`.
- Sustained throughput requires `ram_ctrl` latency of at most 4 cycles per word; beyond that, `overflow` occurs.
- Deasserting `rst` mid-request drops `write` immediately (asynchronous). The FIFO is cleared.

## Structure
- Put `FRAME_WORDS`, `BANK0_BASE` and `BANK1_BASE` defaults in `capiano_pkg`, shared with the VGA reader that consumes `disp_bank`.
- Sub-module `word_fifo`: synchronous FIFO of 52-bit `{addr,data}` entries, with push, pop, full and empty. Depth is `FIFO_DEPTH`.
- The top level holds the packer, the capture FSM and the write FSM.

## Test plan
- Reset, `frame_start`, then bytes 01,02,03,04 with `workdone` 2 cycles after `write` → one write, `addr`=20'h10000, `data`=32'h04030201, `disp_bank` stays 0.
- Full frame, `FRAME_WORDS`=8, `workdone` latency 1 → 8 sequential writes at 10000..10007, one `frame_done` pulse, `disp_bank`=1. The next frame writes at 00000.
- `workdone` held low for 20 cycles during continuous `pix_valid` → the FIFO holds 4 entries, the 5th word is dropped, and `overflow`=1. Later addresses skip the dropped index; `overflow` clears on the next `frame_start`.
- `frame_start` after 6 bytes → word 0 written, the partial bytes 5–6 are discarded, and the next word goes to the new bank base.
- `rst` low while `write`=1 → `write`, `addr`, `data` and `overflow` are 0 in the same cycle and the FIFO is empty. After release, nothing is written until `frame_start`.
- Stray `workdone` pulse in IDLE → no pop, no state change.
